nubus_wait_memory: RTL and testbench

// - Slave-side memory for a NuBus card: the NuBus slave controller presents decoded

---
 rtl/nubus_pkg.sv | 30 +++
 rtl/nubus_bram.sv | 33 +++
 rtl/nubus_wait_memory.sv | 124 ++++++++++++
 tb/tb_nubus_wait_memory.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nubus_pkg.sv
// nubus_pkg
// Shared definitions for the NuBus slave-side memory.
//   - WSTRB_* : byte-strobe patterns for each access type. Any all-zero
//               pattern is a read of the whole word.
//   - nubus_state_t : request handshake states (IDLE -> WAIT -> DONE).
package nubus_pkg;

    localparam logic [3:0] WSTRB_WR_WORD   = 4'b1111;
    localparam logic [3:0] WSTRB_WR_HALF_0 = 4'b0011;
    localparam logic [3:0] WSTRB_WR_HALF_1 = 4'b1100;
    localparam logic [3:0] WSTRB_WR_BYTE_0 = 4'b0001;
    localparam logic [3:0] WSTRB_WR_BYTE_1 = 4'b0010;
    localparam logic [3:0] WSTRB_WR_BYTE_2 = 4'b0100;
    localparam logic [3:0] WSTRB_WR_BYTE_3 = 4'b1000;
    localparam logic [3:0] WSTRB_RD_WORD   = 4'b0000;
    localparam logic [3:0] WSTRB_RD_HALF   = 4'b0000;
    localparam logic [3:0] WSTRB_RD_BYTE   = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } nubus_state_t;

    // Any strobe bit set makes the access a write.
    function automatic logic is_write(input logic [3:0] wstrb);
        return |wstrb;
    endfunction

endpackage

// File: rtl/nubus_bram.sv
// nubus_bram
// Single-port 32-bit RAM with per-byte write enables and a registered
// (synchronous) read port. The array has no reset, so contents survive
// a controller reset.
// Ports:
//   clk    in   1          rising-edge clock
//   we     in   4          byte write enables (bit n -> bits 8n+7:8n)
//   addr   in   ADDR_BITS  word address
//   wdata  in   32         write data
//   rdata  out  32         word at addr as of the previous clock edge
module nubus_bram #(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic [3:0]           we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata
);

    logic [31:0] mem [0:(2**ADDR_BITS)-1];

    // Byte-lane writes and a read-before-write registered output.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/nubus_wait_memory.sv
// nubus_wait_memory
// Slave-side word memory for a NuBus card. Each decoded request from the
// slave controller is answered after a programmable number of wait clocks
// with a one-cycle ready pulse.
// Ports:
//   mem_clk          in   1   clock (rising edge; fed from ~nub_clkn)
//   mem_reset        in   1   synchronous active-high reset
//   mem_valid        in   1   request, held until serviced
//   mem_wstrb        in   4   byte write strobes, 0 = read
//   mem_addr         in   32  byte address (word index in [MEM_ADDR_BITS+1:2])
//   mem_wdata        in   32  write data
//   mem_rdata_o      out  32  read data, held until the next read completes
//   mem_myslot       in   1   request hits this card's slot space
//   mem_myexp        in   1   request hits this card's expansion space
//   mem_wait_clocks  in   3   wait states before ready (sampled in IDLE)
//   mem_ready_o      out  1   one-cycle completion pulse
//   mem_write_o      out  1   high with mem_ready_o for write completions
module nubus_wait_memory
    import nubus_pkg::*;
#(
    parameter int MEM_ADDR_BITS = 8
) (
    input  logic        mem_clk,
    input  logic        mem_reset,
    input  logic        mem_valid,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata_o,
    input  logic        mem_myslot,
    input  logic        mem_myexp,
    input  logic [2:0]  mem_wait_clocks,
    output logic        mem_ready_o,
    output logic        mem_write_o
);

    nubus_state_t             state;
    logic [2:0]               wait_count;
    logic [MEM_ADDR_BITS-1:0] addr_q;
    logic [3:0]               wstrb_q;
    logic [31:0]              wdata_q;

    logic                     accept;
    logic                     access_now;
    logic [MEM_ADDR_BITS-1:0] req_index;
    logic [MEM_ADDR_BITS-1:0] ram_addr;
    logic [3:0]               ram_we;
    logic [31:0]              ram_q;
    logic                     unused_addr_bits;

    assign req_index        = mem_addr[MEM_ADDR_BITS+1:2];
    assign unused_addr_bits = ^{mem_addr[31:MEM_ADDR_BITS+2], mem_addr[1:0]};

    assign accept     = mem_valid && (mem_myslot || mem_myexp);
    assign access_now = (state == ST_WAIT) && (wait_count == 3'd0);

    // In IDLE the RAM already looks up the incoming address, so with zero
    // wait states the read word is ready on the very next edge. Afterwards
    // the latched address keeps the RAM output pointing at the same word.
    assign ram_addr = (state == ST_IDLE) ? req_index : addr_q;

    // Gating with reset guarantees an aborted transaction never writes,
    // even when reset lands on the completing edge.
    assign ram_we = (access_now && !mem_reset) ? wstrb_q : 4'b0000;

    nubus_bram #(
        .ADDR_BITS (MEM_ADDR_BITS)
    ) u_bram (
        .clk   (mem_clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_q)
    );

    // Request handshake FSM. DONE waits for mem_valid to drop so that a
    // request the controller is still holding is not serviced twice.
    always_ff @(posedge mem_clk) begin
        if (mem_reset) begin
            state       <= ST_IDLE;
            wait_count  <= 3'd0;
            addr_q      <= '0;
            wstrb_q     <= 4'b0000;
            wdata_q     <= 32'd0;
            mem_rdata_o <= 32'd0;
            mem_ready_o <= 1'b0;
            mem_write_o <= 1'b0;
        end else begin
            mem_ready_o <= 1'b0;
            mem_write_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        addr_q     <= req_index;
                        wstrb_q    <= mem_wstrb;
                        wdata_q    <= mem_wdata;
                        wait_count <= mem_wait_clocks;
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_count != 3'd0) begin
                        wait_count <= wait_count - 3'd1;
                    end else begin
                        mem_ready_o <= 1'b1;
                        if (is_write(wstrb_q)) begin
                            mem_write_o <= 1'b1;
                        end else begin
                            mem_rdata_o <= ram_q;
                        end
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!mem_valid) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nubus_wait_memory.sv
// tb_nubus_wait_memory
// Self-checking bench for nubus_wait_memory. Each test pushes the expected
// completion of every request onto a scoreboard queue; the request driver
// records what the DUT actually produced, and the test pops both and
// compares them.
module tb_nubus_wait_memory;
    import nubus_pkg::*;

    logic        nub_clkn;
    logic        mem_clk;
    logic        mem_reset;
    logic        mem_valid;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata_o;
    logic        mem_myslot;
    logic        mem_myexp;
    logic [2:0]  mem_wait_clocks;
    logic        mem_ready_o;
    logic        mem_write_o;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        string       tag;
        logic [31:0] rd;
        logic        wr;
        int          lat;
        int          extra;
    } txn_t;

    txn_t sb[$];
    txn_t obs[$];

    nubus_wait_memory #(
        .MEM_ADDR_BITS (8)
    ) dut (
        .mem_clk         (mem_clk),
        .mem_reset       (mem_reset),
        .mem_valid       (mem_valid),
        .mem_wstrb       (mem_wstrb),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata_o     (mem_rdata_o),
        .mem_myslot      (mem_myslot),
        .mem_myexp       (mem_myexp),
        .mem_wait_clocks (mem_wait_clocks),
        .mem_ready_o     (mem_ready_o),
        .mem_write_o     (mem_write_o)
    );

    // NuBus clock is active low; the memory runs on its inverse.
    initial nub_clkn = 1'b1;
    always #5 nub_clkn = ~nub_clkn;
    assign mem_clk = ~nub_clkn;

    // Expected completion: read data seen with ready, write flag, latency in
    // edges from acceptance to ready, and zero extra ready pulses.
    task automatic expect_txn(input string tag, input logic [31:0] rd, input logic wr, input int lat);
        txn_t t;
        t.tag = tag; t.rd = rd; t.wr = wr; t.lat = lat; t.extra = 0;
        sb.push_back(t);
    endtask

    // Drives one request, waits (bounded) for ready, then keeps valid held
    // for 'hold' cycles counting any further ready pulses. A timeout is
    // recorded as latency -1.
    task automatic access(input string tag, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d, input logic [2:0] w, input logic [2:0] w_late,
                          input logic slot, input logic expn, input int hold);
        txn_t t;
        t.tag = tag; t.rd = 32'd0; t.wr = 1'b0; t.lat = -1; t.extra = 0;
        @(negedge mem_clk);
        mem_addr = a; mem_wstrb = s; mem_wdata = d; mem_wait_clocks = w;
        mem_myslot = slot; mem_myexp = expn; mem_valid = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge mem_clk);
            if (c == 1) mem_wait_clocks = w_late;
            if (mem_ready_o) begin
                t.lat = c - 1; t.rd = mem_rdata_o; t.wr = mem_write_o;
                break;
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge mem_clk);
            if (mem_ready_o) t.extra++;
        end
        mem_valid = 1'b0; mem_myslot = 1'b0; mem_myexp = 1'b0;
        repeat (2) begin
            @(negedge mem_clk);
            if (mem_ready_o) t.extra++;
        end
        obs.push_back(t);
    endtask

    task automatic test_reset();
        mem_reset = 1'b1;
        repeat (3) @(negedge mem_clk);
        tests_run += 3;
        if (mem_ready_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_ready: got %b expected 0", mem_ready_o); end
        if (mem_write_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_write: got %b expected 0", mem_write_o); end
        if (mem_rdata_o !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_rdata: got %h expected 00000000", mem_rdata_o); end
        mem_reset = 1'b0;
    endtask

    task automatic test_word();
        txn_t e, o;
        expect_txn("word_wr", 32'h0000_0000, 1'b1, 6);
        access("word_wr", 32'hF000_0000, WSTRB_WR_WORD, 32'h8765_4321, 3'd5, 3'd5, 1'b1, 1'b0, 1);
        expect_txn("word_rd", 32'h8765_4321, 1'b0, 6);
        access("word_rd", 32'hF000_0000, WSTRB_RD_WORD, 32'd0, 3'd5, 3'd5, 1'b1, 1'b0, 1);
        while (sb.size() > 0 && obs.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); tests_run += 4;
            if (o.lat !== e.lat) begin tests_failed++; $display("[TB] FAIL %s latency: got %0d expected %0d", e.tag, o.lat, e.lat); end
            if (o.wr !== e.wr) begin tests_failed++; $display("[TB] FAIL %s write: got %b expected %b", e.tag, o.wr, e.wr); end
            if (o.rd !== e.rd) begin tests_failed++; $display("[TB] FAIL %s rdata: got %h expected %h", e.tag, o.rd, e.rd); end
            if (o.extra !== e.extra) begin tests_failed++; $display("[TB] FAIL %s extra_pulses: got %0d expected %0d", e.tag, o.extra, e.extra); end
        end
    endtask

    task automatic test_halves();
        txn_t e, o;
        expect_txn("half0_wr", 32'h8765_4321, 1'b1, 2);
        access("half0_wr", 32'hF000_0004, WSTRB_WR_HALF_0, 32'h8765_4321, 3'd1, 3'd1, 1'b1, 1'b0, 1);
        expect_txn("half1_wr", 32'h8765_4321, 1'b1, 2);
        access("half1_wr", 32'hF000_0008, WSTRB_WR_HALF_1, 32'h8765_4321, 3'd1, 3'd1, 1'b1, 1'b0, 1);
        expect_txn("half0_rd", 32'h0000_4321, 1'b0, 2);
        access("half0_rd", 32'hF000_0004, WSTRB_RD_HALF, 32'd0, 3'd1, 3'd1, 1'b1, 1'b0, 1);
        expect_txn("half1_rd", 32'h8765_0000, 1'b0, 2);
        access("half1_rd", 32'hF000_0008, WSTRB_RD_HALF, 32'd0, 3'd1, 3'd1, 1'b1, 1'b0, 1);
        while (sb.size() > 0 && obs.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); tests_run += 4;
            if (o.lat !== e.lat) begin tests_failed++; $display("[TB] FAIL %s latency: got %0d expected %0d", e.tag, o.lat, e.lat); end
            if (o.wr !== e.wr) begin tests_failed++; $display("[TB] FAIL %s write: got %b expected %b", e.tag, o.wr, e.wr); end
            if (o.rd !== e.rd) begin tests_failed++; $display("[TB] FAIL %s rdata: got %h expected %h", e.tag, o.rd, e.rd); end
            if (o.extra !== e.extra) begin tests_failed++; $display("[TB] FAIL %s extra_pulses: got %0d expected %0d", e.tag, o.extra, e.extra); end
        end
    endtask

    task automatic test_bytes();
        txn_t e, o;
        logic [3:0]  strb [4];
        logic [31:0] want [4];
        strb[0] = WSTRB_WR_BYTE_0; strb[1] = WSTRB_WR_BYTE_1;
        strb[2] = WSTRB_WR_BYTE_2; strb[3] = WSTRB_WR_BYTE_3;
        want[0] = 32'h0000_0021; want[1] = 32'h0000_4300;
        want[2] = 32'h0065_0000; want[3] = 32'h8700_0000;
        for (int i = 0; i < 4; i++) begin
            expect_txn($sformatf("byte%0d_wr", i), 32'h8765_0000, 1'b1, 3);
            access($sformatf("byte%0d_wr", i), 32'hF000_000C + 32'(4*i), strb[i], 32'h8765_4321,
                   3'd2, 3'd2, 1'b1, 1'b0, 1);
        end
        for (int i = 0; i < 4; i++) begin
            expect_txn($sformatf("byte%0d_rd", i), want[i], 1'b0, 3);
            access($sformatf("byte%0d_rd", i), 32'hF000_000C + 32'(4*i), WSTRB_RD_BYTE, 32'd0,
                   3'd2, 3'd2, 1'b1, 1'b0, 1);
        end
        while (sb.size() > 0 && obs.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); tests_run += 4;
            if (o.lat !== e.lat) begin tests_failed++; $display("[TB] FAIL %s latency: got %0d expected %0d", e.tag, o.lat, e.lat); end
            if (o.wr !== e.wr) begin tests_failed++; $display("[TB] FAIL %s write: got %b expected %b", e.tag, o.wr, e.wr); end
            if (o.rd !== e.rd) begin tests_failed++; $display("[TB] FAIL %s rdata: got %h expected %h", e.tag, o.rd, e.rd); end
            if (o.extra !== e.extra) begin tests_failed++; $display("[TB] FAIL %s extra_pulses: got %0d expected %0d", e.tag, o.extra, e.extra); end
        end
    endtask

    task automatic test_zero_wait_hold();
        txn_t e, o;
        expect_txn("w0_wr_exp", 32'h8700_0000, 1'b1, 1);
        access("w0_wr_exp", 32'hF000_0020, WSTRB_WR_WORD, 32'h1234_5678, 3'd0, 3'd0, 1'b0, 1'b1, 10);
        expect_txn("w0_rd_hold", 32'h1234_5678, 1'b0, 1);
        access("w0_rd_hold", 32'hF000_0020, WSTRB_RD_WORD, 32'd0, 3'd0, 3'd0, 1'b1, 1'b0, 10);
        while (sb.size() > 0 && obs.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); tests_run += 4;
            if (o.lat !== e.lat) begin tests_failed++; $display("[TB] FAIL %s latency: got %0d expected %0d", e.tag, o.lat, e.lat); end
            if (o.wr !== e.wr) begin tests_failed++; $display("[TB] FAIL %s write: got %b expected %b", e.tag, o.wr, e.wr); end
            if (o.rd !== e.rd) begin tests_failed++; $display("[TB] FAIL %s rdata: got %h expected %h", e.tag, o.rd, e.rd); end
            if (o.extra !== e.extra) begin tests_failed++; $display("[TB] FAIL %s extra_pulses: got %0d expected %0d", e.tag, o.extra, e.extra); end
        end
    endtask

    task automatic test_wait_sampled_idle();
        txn_t e, o;
        expect_txn("wlate_short", 32'h0000_4321, 1'b0, 3);
        access("wlate_short", 32'hF000_0004, WSTRB_RD_WORD, 32'd0, 3'd2, 3'd7, 1'b1, 1'b0, 1);
        expect_txn("wlate_long", 32'h8765_0000, 1'b0, 8);
        access("wlate_long", 32'hF000_0008, WSTRB_RD_WORD, 32'd0, 3'd7, 3'd0, 1'b1, 1'b0, 1);
        while (sb.size() > 0 && obs.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); tests_run += 4;
            if (o.lat !== e.lat) begin tests_failed++; $display("[TB] FAIL %s latency: got %0d expected %0d", e.tag, o.lat, e.lat); end
            if (o.wr !== e.wr) begin tests_failed++; $display("[TB] FAIL %s write: got %b expected %b", e.tag, o.wr, e.wr); end
            if (o.rd !== e.rd) begin tests_failed++; $display("[TB] FAIL %s rdata: got %h expected %h", e.tag, o.rd, e.rd); end
            if (o.extra !== e.extra) begin tests_failed++; $display("[TB] FAIL %s extra_pulses: got %0d expected %0d", e.tag, o.extra, e.extra); end
        end
    endtask

    task automatic test_no_decode();
        txn_t e, o;
        int ready_seen = 0;
        int write_seen = 0;
        @(negedge mem_clk);
        mem_addr = 32'hF000_0024; mem_wstrb = WSTRB_WR_WORD; mem_wdata = 32'hFFFF_FFFF;
        mem_wait_clocks = 3'd0; mem_myslot = 1'b0; mem_myexp = 1'b0; mem_valid = 1'b1;
        repeat (12) begin
            @(negedge mem_clk);
            if (mem_ready_o) ready_seen++;
            if (mem_write_o) write_seen++;
        end
        mem_valid = 1'b0;
        tests_run += 2;
        if (ready_seen != 0) begin tests_failed++; $display("[TB] FAIL nodecode_ready: got %0d pulses expected 0", ready_seen); end
        if (write_seen != 0) begin tests_failed++; $display("[TB] FAIL nodecode_write: got %0d pulses expected 0", write_seen); end
        expect_txn("nodecode_rd", 32'h0000_0000, 1'b0, 1);
        access("nodecode_rd", 32'hF000_0024, WSTRB_RD_WORD, 32'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1);
        while (sb.size() > 0 && obs.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); tests_run += 4;
            if (o.lat !== e.lat) begin tests_failed++; $display("[TB] FAIL %s latency: got %0d expected %0d", e.tag, o.lat, e.lat); end
            if (o.wr !== e.wr) begin tests_failed++; $display("[TB] FAIL %s write: got %b expected %b", e.tag, o.wr, e.wr); end
            if (o.rd !== e.rd) begin tests_failed++; $display("[TB] FAIL %s rdata: got %h expected %h", e.tag, o.rd, e.rd); end
            if (o.extra !== e.extra) begin tests_failed++; $display("[TB] FAIL %s extra_pulses: got %0d expected %0d", e.tag, o.extra, e.extra); end
        end
    endtask

    task automatic test_alias();
        txn_t e, o;
        expect_txn("alias_rd", 32'h8765_4321, 1'b0, 1);
        access("alias_rd", 32'hF000_0400, WSTRB_RD_WORD, 32'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1);
        expect_txn("alias_wr", 32'h8765_4321, 1'b1, 1);
        access("alias_wr", 32'hF000_0400, WSTRB_WR_WORD, 32'hA5A5_5A5A, 3'd0, 3'd0, 1'b1, 1'b0, 1);
        expect_txn("alias_rd0", 32'hA5A5_5A5A, 1'b0, 1);
        access("alias_rd0", 32'h0000_0003, WSTRB_RD_WORD, 32'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1);
        while (sb.size() > 0 && obs.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); tests_run += 4;
            if (o.lat !== e.lat) begin tests_failed++; $display("[TB] FAIL %s latency: got %0d expected %0d", e.tag, o.lat, e.lat); end
            if (o.wr !== e.wr) begin tests_failed++; $display("[TB] FAIL %s write: got %b expected %b", e.tag, o.wr, e.wr); end
            if (o.rd !== e.rd) begin tests_failed++; $display("[TB] FAIL %s rdata: got %h expected %h", e.tag, o.rd, e.rd); end
            if (o.extra !== e.extra) begin tests_failed++; $display("[TB] FAIL %s extra_pulses: got %0d expected %0d", e.tag, o.extra, e.extra); end
        end
    endtask

    task automatic test_reset_mid_wait();
        txn_t e, o;
        int ready_seen = 0;
        expect_txn("rst_pre_wr", 32'hA5A5_5A5A, 1'b1, 1);
        access("rst_pre_wr", 32'hF000_0028, WSTRB_WR_WORD, 32'hCAFE_F00D, 3'd0, 3'd0, 1'b1, 1'b0, 1);
        @(negedge mem_clk);
        mem_addr = 32'hF000_0028; mem_wstrb = WSTRB_WR_WORD; mem_wdata = 32'hDEAD_BEEF;
        mem_wait_clocks = 3'd7; mem_myslot = 1'b1; mem_myexp = 1'b0; mem_valid = 1'b1;
        repeat (3) begin
            @(negedge mem_clk);
            if (mem_ready_o) ready_seen++;
        end
        mem_reset = 1'b1; mem_valid = 1'b0; mem_myslot = 1'b0;
        @(negedge mem_clk);
        mem_reset = 1'b0;
        tests_run += 1;
        if (mem_rdata_o !== 32'd0) begin tests_failed++; $display("[TB] FAIL rst_mid_rdata: got %h expected 00000000", mem_rdata_o); end
        repeat (12) begin
            @(negedge mem_clk);
            if (mem_ready_o) ready_seen++;
        end
        tests_run += 1;
        if (ready_seen != 0) begin tests_failed++; $display("[TB] FAIL rst_mid_ready: got %0d pulses expected 0", ready_seen); end
        expect_txn("rst_post_rd", 32'hCAFE_F00D, 1'b0, 1);
        access("rst_post_rd", 32'hF000_0028, WSTRB_RD_WORD, 32'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1);
        while (sb.size() > 0 && obs.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); tests_run += 4;
            if (o.lat !== e.lat) begin tests_failed++; $display("[TB] FAIL %s latency: got %0d expected %0d", e.tag, o.lat, e.lat); end
            if (o.wr !== e.wr) begin tests_failed++; $display("[TB] FAIL %s write: got %b expected %b", e.tag, o.wr, e.wr); end
            if (o.rd !== e.rd) begin tests_failed++; $display("[TB] FAIL %s rdata: got %h expected %h", e.tag, o.rd, e.rd); end
            if (o.extra !== e.extra) begin tests_failed++; $display("[TB] FAIL %s extra_pulses: got %0d expected %0d", e.tag, o.extra, e.extra); end
        end
    endtask

    // Hard stop in case a wait somewhere never returns.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        mem_reset = 1'b1; mem_valid = 1'b0; mem_wstrb = 4'b0000; mem_addr = 32'd0;
        mem_wdata = 32'd0; mem_myslot = 1'b0; mem_myexp = 1'b0; mem_wait_clocks = 3'd0;
        test_reset();
        test_word();
        test_halves();
        test_bytes();
        test_zero_wait_hold();
        test_wait_sampled_idle();
        test_no_decode();
        test_alias();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
